// File: rtl/secure_mode_fsm_pkg.sv
// secure_fsm_pkg: privilege-mode state/command encodings and the legal-transition table.
// Revision 1.0
`default_nettype none

package secure_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_USER   = 3'd1,
    ST_SUPER  = 3'd2,
    ST_ARMED  = 3'd3,
    ST_DEBUG  = 3'd4,
    ST_LOCKED = 3'd6
  } state_e;

  localparam logic [2:0] CMD_NOP      = 3'd0;
  localparam logic [2:0] CMD_GO_USER  = 3'd1;
  localparam logic [2:0] CMD_GO_SUPER = 3'd2;
  localparam logic [2:0] CMD_UNLOCK   = 3'd3;
  localparam logic [2:0] CMD_GO_DEBUG = 3'd4;
  localparam logic [2:0] CMD_EXIT     = 3'd5;
  localparam logic [2:0] CMD_UNDEF    = 3'd7;

  function automatic logic is_legal(state_e s, logic [2:0] c);
    logic ok;
    ok = (c == CMD_NOP);
    case (s)
      ST_IDLE:  ok = ok | (c == CMD_GO_USER) | (c == CMD_GO_SUPER);
      ST_USER:  ok = ok | (c == CMD_EXIT);
      ST_SUPER: ok = ok | (c == CMD_UNLOCK) | (c == CMD_EXIT);
      ST_ARMED: ok = ok | (c == CMD_GO_DEBUG);
      ST_DEBUG: ok = ok | (c == CMD_EXIT);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Destination of a legal non-NOP command; only meaningful when is_legal() holds.
  function automatic state_e legal_target(logic [2:0] c);
    state_e t;
    case (c)
      CMD_GO_USER:  t = ST_USER;
      CMD_GO_SUPER: t = ST_SUPER;
      CMD_UNLOCK:   t = ST_ARMED;
      CMD_GO_DEBUG: t = ST_DEBUG;
      default:      t = ST_IDLE;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/secure_mode_fsm_sat_counter.sv
// sat_counter: synchronous clear / increment counter that sticks at all-ones.
// Revision 1.0
`default_nettype none

module sat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/secure_mode_fsm.sv
// secure_mode_fsm: privilege-mode controller with violation lockout and illegal-state recovery.
// Revision 1.0
`default_nettype none

module secure_mode_fsm
  import secure_fsm_pkg::*;
#(
  parameter int CMD_W      = 3,
  parameter int MAX_FAULTS = 3,
  parameter int FAULT_W    = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  input  logic [CMD_W-1:0]   cmd_i,
  output logic               cmd_ready_o,
  output logic [2:0]         mode_o,
  output logic               locked_o,
  output logic               fault_o,
  output logic [FAULT_W-1:0] err_cnt_o
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               fault_q, locked_q;
  logic               accept, viol, legal_clr, fault_set;
  logic [2:0]         cmd;
  logic [FAULT_W-1:0] err_cnt;

  // Wide command codes above EXIT collapse onto one undefined code.
  assign cmd         = (cmd_i > CMD_W'(5)) ? CMD_UNDEF : cmd_i[2:0];
  assign cmd_ready_o = (state_q != ST_LOCKED);
  assign accept      = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    viol      = 1'b0;
    legal_clr = 1'b0;
    fault_set = 1'b0;
    case (state_q)
      ST_IDLE, ST_USER, ST_SUPER, ST_DEBUG: begin
        if (accept && (cmd != CMD_NOP)) begin
          if (is_legal(state_q, cmd)) begin
            state_d   = legal_target(cmd);
            legal_clr = 1'b1;
          end else begin
            viol = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (accept) begin
          if (cmd == CMD_GO_DEBUG) begin
            state_d   = ST_DEBUG;
            legal_clr = 1'b1;
          end else if (cmd != CMD_NOP) begin
            state_d = ST_SUPER;
            viol    = 1'b1;
          end
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d = ST_SUPER;
          viol    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LOCKED: state_d = ST_LOCKED;
      default: begin
        state_d   = ST_IDLE;
        fault_set = 1'b1;
      end
    endcase
    if (viol && (err_cnt == FAULT_W'(MAX_FAULTS - 1))) begin
      state_d = ST_LOCKED;
    end
    if ((state_d == ST_ARMED) && (state_q != ST_ARMED)) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      fault_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      locked_q <= (state_d == ST_LOCKED);
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  sat_counter #(
    .W (FAULT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (legal_clr),
    .inc_i (viol),
    .cnt_o (err_cnt)
  );

  assign mode_o    = state_q;
  assign locked_o  = locked_q;
  assign fault_o   = fault_q;
  assign err_cnt_o = err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_secure_mode_fsm.sv
// tb_secure_mode_fsm: directed self-checking bench for secure_mode_fsm.
// Revision 1.0
`default_nettype none

module tb_secure_mode_fsm;
  import secure_fsm_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid_i;
  logic [2:0] cmd_i;
  logic       cmd_ready_o;
  logic [2:0] mode_o;
  logic       locked_o;
  logic       fault_o;
  logic [1:0] err_cnt_o;

  int errors;
  int checks;

  secure_mode_fsm #(
    .CMD_W      (3),
    .MAX_FAULTS (3),
    .FAULT_W    (2),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_i       (cmd_i),
    .cmd_ready_o (cmd_ready_o),
    .mode_o      (mode_o),
    .locked_o    (locked_o),
    .fault_o     (fault_o),
    .err_cnt_o   (err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for a single edge; returns 1 ns after that edge.
  task automatic send(input logic [2:0] c);
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    cmd_i       = CMD_NOP;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_i       = CMD_NOP;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mode_o !== 3'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", mode_o); end
    checks++; if (err_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_cnt_o); end
    checks++; if ({locked_o, fault_o, cmd_ready_o} !== 3'b001) begin errors++; $display("FAIL reset_flags got=%b exp=001", {locked_o, fault_o, cmd_ready_o}); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_privilege_walk();
    send(CMD_GO_SUPER);
    checks++; if (mode_o !== 3'd2) begin errors++; $display("FAIL walk_super got=%0d exp=2", mode_o); end
    send(CMD_UNLOCK);
    checks++; if (mode_o !== 3'd3) begin errors++; $display("FAIL walk_armed got=%0d exp=3", mode_o); end
    send(CMD_GO_DEBUG);
    checks++; if (mode_o !== 3'd4) begin errors++; $display("FAIL walk_debug got=%0d exp=4", mode_o); end
    send(CMD_EXIT);
    checks++; if (mode_o !== 3'd0) begin errors++; $display("FAIL walk_exit got=%0d exp=0", mode_o); end
    checks++; if (err_cnt_o !== 2'd0) begin errors++; $display("FAIL walk_err got=%0d exp=0", err_cnt_o); end
  endtask

  task automatic test_undefined_and_nop();
    send(3'd6);
    checks++; if (mode_o !== 3'd0 || err_cnt_o !== 2'd1) begin errors++; $display("FAIL undef_cmd got mode=%0d err=%0d exp mode=0 err=1", mode_o, err_cnt_o); end
    send(CMD_NOP);
    checks++; if (mode_o !== 3'd0 || err_cnt_o !== 2'd1) begin errors++; $display("FAIL nop_hold got mode=%0d err=%0d exp mode=0 err=1", mode_o, err_cnt_o); end
    cmd_i = CMD_GO_USER;
    idle_cycle();
    checks++; if (mode_o !== 3'd0) begin errors++; $display("FAIL no_valid got=%0d exp=0", mode_o); end
    send(CMD_GO_USER);
    checks++; if (mode_o !== 3'd1 || err_cnt_o !== 2'd0) begin errors++; $display("FAIL legal_clears got mode=%0d err=%0d exp mode=1 err=0", mode_o, err_cnt_o); end
    send(CMD_EXIT);
  endtask

  task automatic test_armed_timeout();
    send(CMD_GO_SUPER);
    send(CMD_UNLOCK);
    checks++; if (mode_o !== 3'd3) begin errors++; $display("FAIL armed_entry got=%0d exp=3", mode_o); end
    for (int i = 0; i < 7; i++) begin
      idle_cycle();
      checks++; if (mode_o !== 3'd3) begin errors++; $display("FAIL armed_wait%0d got=%0d exp=3", i, mode_o); end
    end
    idle_cycle();
    checks++; if (mode_o !== 3'd2) begin errors++; $display("FAIL armed_timeout got=%0d exp=2", mode_o); end
    checks++; if (err_cnt_o !== 2'd1) begin errors++; $display("FAIL timeout_err got=%0d exp=1", err_cnt_o); end
  endtask

  task automatic test_timeout_race();
    send(CMD_UNLOCK);
    repeat (7) idle_cycle();
    checks++; if (mode_o !== 3'd3) begin errors++; $display("FAIL race_armed got=%0d exp=3", mode_o); end
    send(CMD_GO_DEBUG);
    checks++; if (mode_o !== 3'd4 || err_cnt_o !== 2'd0) begin errors++; $display("FAIL race_debug got mode=%0d err=%0d exp mode=4 err=0", mode_o, err_cnt_o); end
    send(CMD_EXIT);
  endtask

  task automatic test_illegal_state();
    force dut.state_q = state_e'(3'd5);
    cmd_valid_i = 1'b1;
    cmd_i       = CMD_GO_USER;
    @(posedge clk);
    #1;
    release dut.state_q;
    cmd_valid_i = 1'b0;
    cmd_i       = CMD_NOP;
    checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL fault_set got=%b exp=1", fault_o); end
    idle_cycle();
    checks++; if (mode_o !== 3'd0 || err_cnt_o !== 2'd0) begin errors++; $display("FAIL recover got mode=%0d err=%0d exp mode=0 err=0", mode_o, err_cnt_o); end
    send(CMD_GO_USER);
    send(CMD_EXIT);
    checks++; if (fault_o !== 1'b1 || mode_o !== 3'd0) begin errors++; $display("FAIL fault_sticky got fault=%b mode=%0d exp fault=1 mode=0", fault_o, mode_o); end
  endtask

  task automatic test_lockout();
    send(CMD_GO_USER);
    checks++; if (mode_o !== 3'd1 || err_cnt_o !== 2'd0) begin errors++; $display("FAIL lk_user got mode=%0d err=%0d exp mode=1 err=0", mode_o, err_cnt_o); end
    send(CMD_GO_SUPER);
    checks++; if (mode_o !== 3'd1 || err_cnt_o !== 2'd1) begin errors++; $display("FAIL lk_v1 got mode=%0d err=%0d exp mode=1 err=1", mode_o, err_cnt_o); end
    send(CMD_GO_SUPER);
    checks++; if (mode_o !== 3'd1 || err_cnt_o !== 2'd2) begin errors++; $display("FAIL lk_v2 got mode=%0d err=%0d exp mode=1 err=2", mode_o, err_cnt_o); end
    send(CMD_GO_SUPER);
    checks++; if (mode_o !== 3'd6 || err_cnt_o !== 2'd3) begin errors++; $display("FAIL lk_v3 got mode=%0d err=%0d exp mode=6 err=3", mode_o, err_cnt_o); end
    checks++; if (locked_o !== 1'b1 || cmd_ready_o !== 1'b0) begin errors++; $display("FAIL lk_flags got locked=%b ready=%b exp locked=1 ready=0", locked_o, cmd_ready_o); end
    send(CMD_EXIT);
    checks++; if (mode_o !== 3'd6 || err_cnt_o !== 2'd3) begin errors++; $display("FAIL lk_hold got mode=%0d err=%0d exp mode=6 err=3", mode_o, err_cnt_o); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mode_o !== 3'd0 || err_cnt_o !== 2'd0) begin errors++; $display("FAIL async_rst got mode=%0d err=%0d exp mode=0 err=0", mode_o, err_cnt_o); end
    checks++; if (locked_o !== 1'b0 || fault_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errors++; $display("FAIL async_flags got locked=%b fault=%b ready=%b exp 0 0 1", locked_o, fault_o, cmd_ready_o); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(CMD_GO_SUPER);
    checks++; if (mode_o !== 3'd2) begin errors++; $display("FAIL post_rst got=%0d exp=2", mode_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_privilege_walk();
    test_undefined_and_nop();
    test_armed_timeout();
    test_timeout_race();
    test_illegal_state();
    test_lockout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
